// File: rtl/plot_arbiter_if.sv
// Pixel-port bundle for plot_arbiter: requester side, VGA write side and clear control/status.
// The arbiter connects through the slave modport; the requesters/VGA glue use master.
interface plot_arbiter_if #(
    parameter int N_REQ = 3
);
    logic                 clear_req;
    logic [N_REQ-1:0]     req;
    logic [8*N_REQ-1:0]   req_x;
    logic [7*N_REQ-1:0]   req_y;
    logic [3*N_REQ-1:0]   req_colour;
    logic [N_REQ-1:0]     gnt;
    logic [7:0]           x;
    logic [6:0]           y;
    logic [2:0]           colour;
    logic                 plot;
    logic                 busy;
    logic                 clear_done;

    modport master (
        output clear_req, req, req_x, req_y, req_colour,
        input  gnt, x, y, colour, plot, busy, clear_done
    );

    modport slave (
        input  clear_req, req, req_x, req_y, req_colour,
        output gnt, x, y, colour, plot, busy, clear_done
    );
endinterface

// File: rtl/plot_arbiter.sv
// Round-robin arbiter for the single VGA pixel write port, with a built-in 160x120 black clear sweep.
// Optional: define PLOT_ARBITER_CLEAR_ON_RESET_EN to start a full-screen clear on reset release.
module plot_arbiter #(
    parameter int N_REQ = 3
) (
    input  logic          clk,
    input  logic          reset,
    plot_arbiter_if.slave bus
);

    localparam int          PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0]  X_LAST = 8'd159;
    localparam logic [6:0]  Y_LAST = 7'd119;

    typedef enum logic {
        SERVE = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t             r_state, w_state_next;
    logic [PTR_W-1:0]   r_ptr, w_ptr_next;
    logic [7:0]         r_sx, w_sx_next;
    logic [6:0]         r_sy, w_sy_next;
    logic [7:0]         r_x, w_x_next;
    logic [6:0]         r_y, w_y_next;
    logic [2:0]         r_colour, w_colour_next;
    logic               r_plot, w_plot_next;
    logic               r_busy, w_busy_next;
    logic               r_done, w_done_next;

    logic               w_init_clear;
    logic               w_serve;
    logic               w_start_clear;
    logic [N_REQ-1:0]   w_gnt;
    logic               w_gnt_valid;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic [PTR_W:0]     w_idx;
    logic [7:0]         w_sel_x;
    logic [6:0]         w_sel_y;
    logic [2:0]         w_sel_colour;
    logic               w_onscreen;

`ifdef PLOT_ARBITER_CLEAR_ON_RESET_EN
    logic r_init_clear;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_init_clear <= 1'b1;
        end else if (w_start_clear) begin
            r_init_clear <= 1'b0;
        end
    end

    assign w_init_clear = r_init_clear;
`else
    assign w_init_clear = 1'b0;
`endif

    // A registered busy still high means the last clear pixel is on the port; grants wait one cycle more.
    assign w_serve       = reset && (r_state == SERVE) && !r_busy;
    assign w_start_clear = w_serve && (bus.clear_req || w_init_clear);

    always_comb begin
        w_gnt       = '0;
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        w_idx       = '0;
        if (w_serve && !w_start_clear) begin
            for (int k = 0; k < N_REQ; k++) begin
                w_idx = {1'b0, r_ptr} + (PTR_W+1)'(k);
                if (w_idx >= (PTR_W+1)'(N_REQ)) begin
                    w_idx = w_idx - (PTR_W+1)'(N_REQ);
                end
                if (!w_gnt_valid && bus.req[w_idx[PTR_W-1:0]]) begin
                    w_gnt_valid = 1'b1;
                    w_gnt_idx   = w_idx[PTR_W-1:0];
                end
            end
            if (w_gnt_valid) begin
                w_gnt[w_gnt_idx] = 1'b1;
            end
        end
    end

    assign w_sel_x      = bus.req_x[8*w_gnt_idx +: 8];
    assign w_sel_y      = bus.req_y[7*w_gnt_idx +: 7];
    assign w_sel_colour = bus.req_colour[3*w_gnt_idx +: 3];
    assign w_onscreen   = (w_sel_x <= X_LAST) && (w_sel_y <= Y_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= SERVE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Off-screen grants still advance the pointer so a stray requester cannot stall the others.
    always_comb begin
        w_state_next  = r_state;
        w_ptr_next    = r_ptr;
        w_sx_next     = r_sx;
        w_sy_next     = r_sy;
        w_x_next      = r_x;
        w_y_next      = r_y;
        w_colour_next = r_colour;
        w_plot_next   = 1'b0;
        w_busy_next   = 1'b0;
        w_done_next   = 1'b0;
        case (r_state)
            SERVE: begin
                if (w_start_clear) begin
                    w_state_next  = CLEAR;
                    w_sx_next     = '0;
                    w_sy_next     = '0;
                    w_x_next      = '0;
                    w_y_next      = '0;
                    w_colour_next = '0;
                    w_plot_next   = 1'b1;
                    w_busy_next   = 1'b1;
                end else if (w_gnt_valid) begin
                    w_ptr_next = (w_gnt_idx == PTR_W'(N_REQ-1)) ? '0 : w_gnt_idx + 1'b1;
                    if (w_onscreen) begin
                        w_x_next      = w_sel_x;
                        w_y_next      = w_sel_y;
                        w_colour_next = w_sel_colour;
                        w_plot_next   = 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (r_sx == X_LAST) begin
                    w_sx_next = '0;
                    w_sy_next = r_sy + 7'd1;
                end else begin
                    w_sx_next = r_sx + 8'd1;
                end
                w_x_next      = w_sx_next;
                w_y_next      = w_sy_next;
                w_colour_next = '0;
                w_plot_next   = 1'b1;
                w_busy_next   = 1'b1;
                if ((r_sx == X_LAST - 8'd1) && (r_sy == Y_LAST)) begin
                    w_done_next  = 1'b1;
                    w_state_next = SERVE;
                end
            end
            default: begin
                w_state_next = SERVE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr    <= '0;
            r_sx     <= '0;
            r_sy     <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_ptr    <= w_ptr_next;
            r_sx     <= w_sx_next;
            r_sy     <= w_sy_next;
            r_x      <= w_x_next;
            r_y      <= w_y_next;
            r_colour <= w_colour_next;
            r_plot   <= w_plot_next;
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
        end
    end

    assign bus.gnt        = w_gnt;
    assign bus.x          = r_x;
    assign bus.y          = r_y;
    assign bus.colour     = r_colour;
    assign bus.plot       = r_plot;
    assign bus.busy       = r_busy;
    assign bus.clear_done = r_done;

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter: vector table for reset/round-robin/off-screen,
// hand sequences for the clear sweep, pre-emption, clear_req during clear and mid-clear reset.
module tb_plot_arbiter;

    localparam int NPIX = 19200;

    logic clk;
    logic reset;
    int   nCompared;
    int   nMismatched;

    plot_arbiter_if #(.N_REQ(3)) bus ();

    plot_arbiter #(.N_REQ(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [23:0] rx;
        logic [20:0] ry;
        logic [8:0]  rc;
        logic [2:0]  eGnt;
        logic        ePlot;
        logic [7:0]  eX;
        logic [6:0]  eY;
        logic [2:0]  eCol;
        logic        eBusy;
        logic        chkXY;
    } vec_t;

    vec_t vecs [0:17];

    localparam logic [23:0] DX = {8'd50, 8'd30, 8'd10};
    localparam logic [20:0] DY = {7'd60, 7'd40, 7'd20};
    localparam logic [8:0]  DC = {3'd3, 3'd2, 3'd1};

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset          = v.rst;
        bus.clear_req  = 1'b0;
        bus.req        = v.req;
        bus.req_x      = v.rx;
        bus.req_y      = v.ry;
        bus.req_colour = v.rc;
    endtask

    task automatic checkGnt(input string name, input logic [2:0] eg);
        nCompared++;
        if (bus.gnt !== eg) begin
            nMismatched++;
            $display("[TB] FAIL %s gnt: got %b want %b", name, bus.gnt, eg);
        end
    endtask

    task automatic checkOutput(input string name, input logic [7:0] ex, input logic [6:0] ey,
                               input logic [2:0] ec, input logic ep, input logic eb,
                               input logic ed, input bit chkXY);
        logic [20:0] act;
        logic [20:0] exp;
        act = {bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.clear_done};
        exp = {ex, ey, ec, ep, eb, ed};
        if (!chkXY) begin
            act[20:3] = '0;
            exp[20:3] = '0;
        end
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got x=%0d y=%0d col=%0d plot=%b busy=%b done=%b, want x=%0d y=%0d col=%0d plot=%b busy=%b done=%b (xy checked=%0d)",
                     name, bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.clear_done,
                     ex, ey, ec, ep, eb, ed, chkXY);
        end
    endtask

    // Walks clear pixels firstPix..lastPix, one per edge, in raster order.
    task automatic sweepCheck(input string name, input int firstPix, input int lastPix);
        int gntErr;
        int pixErr;
        int badPix;
        logic [20:0] act;
        logic [20:0] exp;
        gntErr = 0;
        pixErr = 0;
        badPix = -1;
        for (int j = firstPix; j <= lastPix; j++) begin
            @(negedge clk);
            #1;
            if (bus.gnt !== 3'b000) gntErr++;
            @(posedge clk);
            #1;
            act = {bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.clear_done};
            exp = {8'(j % 160), 7'(j / 160), 3'd0, 1'b1, 1'b1, (j == NPIX - 1)};
            if (act !== exp) begin
                if (badPix < 0) badPix = j;
                pixErr++;
            end
        end
        nCompared++;
        if (gntErr != 0) begin
            nMismatched++;
            $display("[TB] FAIL %s_gnt: got %0d cycles with gnt!=0, want 0", name, gntErr);
        end
        nCompared++;
        if (pixErr != 0) begin
            nMismatched++;
            $display("[TB] FAIL %s_pixels: got %0d bad pixels (first index %0d), want 0", name, pixErr, badPix);
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, want $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nCompared      = 0;
        nMismatched    = 0;
        reset          = 1'b0;
        bus.clear_req  = 1'b0;
        bus.req        = 3'b000;
        bus.req_x      = DX;
        bus.req_y      = DY;
        bus.req_colour = DC;

        vecs[0]  = '{1'b0, 3'b111, DX, DY, DC, 3'b000, 1'b0, 8'd0,   7'd0,   3'd0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 3'b000, DX, DY, DC, 3'b000, 1'b0, 8'd0,   7'd0,   3'd0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 3'b111, DX, DY, DC, 3'b001, 1'b1, 8'd10,  7'd20,  3'd1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 3'b111, DX, DY, DC, 3'b010, 1'b1, 8'd30,  7'd40,  3'd2, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 3'b111, DX, DY, DC, 3'b100, 1'b1, 8'd50,  7'd60,  3'd3, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 3'b111, DX, DY, DC, 3'b001, 1'b1, 8'd10,  7'd20,  3'd1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 3'b111, DX, DY, DC, 3'b010, 1'b1, 8'd30,  7'd40,  3'd2, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 3'b111, DX, DY, DC, 3'b100, 1'b1, 8'd50,  7'd60,  3'd3, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 3'b000, DX, DY, DC, 3'b000, 1'b0, 8'd50,  7'd60,  3'd3, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 3'b010, DX, DY, DC, 3'b010, 1'b1, 8'd30,  7'd40,  3'd2, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 3'b101, DX, DY, DC, 3'b100, 1'b1, 8'd50,  7'd60,  3'd3, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 3'b001, {8'd50, 8'd30, 8'd200}, {7'd60, 7'd40, 7'd5}, DC,
                     3'b001, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 3'b011, DX, DY, DC, 3'b010, 1'b1, 8'd30,  7'd40,  3'd2, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 3'b100, DX, {7'd120, 7'd40, 7'd20}, DC,
                     3'b100, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 3'b111, DX, DY, DC, 3'b001, 1'b1, 8'd10,  7'd20,  3'd1, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 3'b010, {8'd50, 8'd159, 8'd10}, {7'd60, 7'd119, 7'd20}, {3'd3, 3'd5, 3'd1},
                     3'b010, 1'b1, 8'd159, 7'd119, 3'd5, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 3'b001, {8'd50, 8'd30, 8'd160}, {7'd60, 7'd40, 7'd0}, {3'd3, 3'd2, 3'd6},
                     3'b001, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 3'b110, DX, DY, DC, 3'b010, 1'b1, 8'd30,  7'd40,  3'd2, 1'b0, 1'b1};

        for (int i = 0; i < 18; i++) begin
`ifdef PLOT_ARBITER_CLEAR_ON_RESET_EN
            if (i == 2) begin
                reset   = 1'b1;
                bus.req = 3'b000;
                sweepCheck("poweron_clear", 0, NPIX - 1);
                @(posedge clk);
                #1;
            end
`endif
            applyStimulus(vecs[i]);
            #1;
            checkGnt($sformatf("vec%0d", i), vecs[i].eGnt);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d", i), vecs[i].eX, vecs[i].eY, vecs[i].eCol,
                        vecs[i].ePlot, vecs[i].eBusy, 1'b0, vecs[i].chkXY);
        end

        // Full sweep with requester 1 held: pointer is 2, so it would win if not pre-empted.
        @(negedge clk);
        bus.req_x      = DX;
        bus.req_y      = DY;
        bus.req_colour = DC;
        bus.req        = 3'b010;
        bus.clear_req  = 1'b1;
        #1;
        checkGnt("clear_start", 3'b000);
        @(posedge clk);
        #1;
        bus.clear_req = 1'b0;
        checkOutput("clear_pix0", 8'd0, 7'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        sweepCheck("clear_sweep", 1, NPIX - 1);
        @(negedge clk);
        #1;
        checkGnt("clear_tail_gnt", 3'b000);
        @(posedge clk);
        #1;
        checkOutput("clear_busy_drop", 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        checkGnt("resume_gnt", 3'b010);
        @(posedge clk);
        #1;
        checkOutput("resume_pix", 8'd30, 7'd40, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        bus.req = 3'b000;

        // Second clear: a repeat clear_req mid-sweep must not restart it, then reset at pixel 5000.
        @(negedge clk);
        bus.clear_req = 1'b1;
        #1;
        checkGnt("clear2_start", 3'b000);
        @(posedge clk);
        #1;
        bus.clear_req = 1'b0;
        checkOutput("clear2_pix0", 8'd0, 7'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        sweepCheck("clear2_a", 1, 100);
        bus.clear_req = 1'b1;
        sweepCheck("clear2_ignore", 101, 101);
        bus.clear_req = 1'b0;
        sweepCheck("clear2_b", 102, 5000);

        reset   = 1'b0;
        bus.req = 3'b111;
        @(negedge clk);
        #1;
        checkGnt("midclear_reset_gnt", 3'b000);
        @(posedge clk);
        #1;
        checkOutput("midclear_reset", 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset   = 1'b1;
        bus.req = 3'b000;
`ifdef PLOT_ARBITER_CLEAR_ON_RESET_EN
        sweepCheck("reset_reclear", 0, NPIX - 1);
        @(posedge clk);
        #1;
        checkOutput("reclear_done", 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        @(posedge clk);
        #1;
        checkOutput("idle_after_reset", 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
        @(negedge clk);
        bus.req = 3'b001;
        #1;
        checkGnt("post_reset_gnt", 3'b001);
        @(posedge clk);
        #1;
        checkOutput("post_reset_pix", 8'd10, 7'd20, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/plot_arbiter.md
# plot_arbiter

Shares the single VGA-adapter pixel write port (x, y, colour, plot) between the game's pixel requesters (user ship, enemy ship, bullets) and a built-in full-screen clear engine. One pixel is written per clock. Requesters are served round-robin, and a clear request pre-empts them for a 160×120 black sweep. Sits between the per-object draw logic and the VGA adapter.

## Interface
- N_REQ, 3, number of pixel requesters (1..8)
- clk  input  1  system clock (50 MHz)
- reset  input  1  synchronous, active-low reset
- clear_req  input  1  one-cycle pulse: start full-screen clear
- req  input  N_REQ  per-requester pixel request, level, held until granted
- req_x  input  8*N_REQ  flattened x, requester i at [8i+7:8i]
- req_y  input  7*N_REQ  flattened y, requester i at [7i+6:7i]
- req_colour  input  3*N_REQ  flattened colour, requester i at [3i+2:3i]
- gnt  output  N_REQ  combinational one-hot grant
- x  output  8  registered pixel x to VGA adapter
- y  output  7  registered pixel y to VGA adapter
- colour  output  3  registered pixel colour
- plot  output  1  registered write enable
- busy  output  1  high while clearing
- clear_done  output  1  one-cycle pulse with the last clear pixel

## Operation
- FSM states: SERVE and CLEAR. Reset state is SERVE.
- SERVE:
  - gnt[i] = 1 for the first asserted req in round-robin order starting at pointer p. gnt is 0 if no req is asserted, if clear_req = 1, or while reset = 0.
  - On the clock edge, the granted requester's x/y/colour are registered and plot = 1. Then p becomes i+1 mod N_REQ.
  - If no grant is issued, plot = 0 and x/y/colour hold their previous values.
- Off-screen drop: a grant where req_x ≥ 160 or req_y ≥ 120 is still consumed (gnt high, p advances), but plot = 0 for that pixel.
- clear_req in SERVE: moves to CLEAR, resets the sweep counters to (0,0), and issues no grant that cycle.
- CLEAR:
  - One pixel is output per cycle, colour 000, plot = 1.
  - Order is x 0..159 inner and y 0..119 outer, 19200 pixels total.
  - gnt = 0 throughout. Pending requests stay pending.
- Last pixel (159,119): clear_done = 1 and the FSM returns to SERVE. Servicing resumes the next cycle with the pointer p unchanged.
- clear_req during CLEAR is ignored; the sweep is not restarted.
- Sweep counters: x counter 8 bits, wraps 159→0 and increments y; y counter 7 bits, terminal value 119. No division or modulo on a flat counter.
- Requester contract: a requester advances to its next pixel on the edge where it sees gnt = 1. It may keep req high for back-to-back pixels.

## Timing
- Reset (reset = 0 at an edge):
  - x = 0, y = 0, colour = 000, plot = 0, busy = 0, clear_done = 0, p = 0.
  - FSM goes to SERVE and the sweep counters go to 0.
  - Takes effect from any state, including mid-clear; an aborted clear gives no clear_done.
- Grant-to-plot latency: gnt high in cycle k → pixel on x/y/colour with plot = 1 in cycle k+1.
- Clear latency:
  - clear_req sampled at edge k → busy = 1 and pixel (0,0) plotted from edge k.
  - Pixel (159,119) with clear_done = 1 from edge k+19199.
  - busy = 0 from edge k+19200, and grants are possible in that cycle.
- Throughput: one plot per cycle under continuous requests. With N active requesters, each gets one grant every N cycles.

## Configuration
- PLOT_ARBITER_CLEAR_ON_RESET_EN:
  - Defined: on reset release, the FSM enters CLEAR in place of SERVE. busy = 1 and pixel (0,0) is plotted on the first edge with reset = 1. clear_done fires at the end as normal.
  - Undefined: the block idles in SERVE after reset; the screen is cleared only by clear_req.

## Test plan
- Reset: drive reset = 0 with arbitrary inputs → x = 0, y = 0, colour = 0, plot = 0, gnt = 0, busy = 0.
- Round-robin: hold req = 3'b111 for 6 cycles → gnt sequence 001, 010, 100, 001, 010, 100. Plotted x/y/colour match the granted requester one cycle later.
- Clear sweep: pulse clear_req with no requests → exactly 19200 consecutive plots of colour 0 in raster order, ending at (159,119). clear_done pulses once, coincident with the last pixel. busy drops the next cycle.
- Pre-emption: req[1] held, pulse clear_req → gnt = 0 for all 19200 clear cycles. gnt[1] asserts on the first cycle after busy falls.
- Off-screen drop: req[0] with x = 200, y = 5 → gnt[0] = 1, plot = 0 next cycle, and p advances to 1.
- Mid-clear reset: reset = 0 at pixel 5000 → outputs return to reset values, no clear_done. With PLOT_ARBITER_CLEAR_ON_RESET_EN defined, the sweep restarts at (0,0) after release.
